param_bubble_sorter: RTL and testbench

- Parametrised successor of the team's fixed 8×4-bit load/sort/send sorter.
- Loads DEPTH words of DATA_W bits, then bubble-sorts them in place, one compare/swap per cycle.
- Sort order (ascending or descending) is selected per sort run.
- Streams the sorted array out with a valid strobe, then returns to idle.
- Sits between a serial data source and a consumer as a standalone sort engine.

---
 rtl/param_bubble_sorter_if.sv | 26 ++
 rtl/param_bubble_sorter.sv | 201 ++++++++++++++++++++
 tb/tb_param_bubble_sorter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/param_bubble_sorter_if.sv
// Handshake and data bundle for param_bubble_sorter.
// The master side drives commands and load data; the slave side returns status and sorted data.
interface param_bubble_sorter_if #(
  parameter int DATA_W = 4
) ();
  logic              load;
  logic              sort;
  logic              send;
  logic              descend;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              busy;
  logic              waiting;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;

  modport master (
    output load, sort, send, descend, data_in,
    input  ready, busy, waiting, data_out, data_out_valid
  );

  modport slave (
    input  load, sort, send, descend, data_in,
    output ready, busy, waiting, data_out, data_out_valid
  );
endinterface

// File: rtl/param_bubble_sorter.sv
// Load/sort/send engine: loads DEPTH words, bubble-sorts them in place (one compare per cycle), streams them out.
// Optional build macro SORT_EARLY_EXIT_EN ends the sort after the first pass that makes no swap.
module param_bubble_sorter #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(DEPTH) + 1
) (
  input logic                   clk,
  input logic                   rst,
  param_bubble_sorter_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] PASS_LAST = IDX_W'(DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SORT = 3'd2,
    S_WAIT = 3'd3,
    S_SEND = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] arr_q [DEPTH];
  logic [DATA_W-1:0] arr_d [DEPTH];
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  pass_q, pass_d;
  logic              desc_q, desc_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              waiting_q, waiting_d;

  logic [IDX_W-1:0]  idx_nxt_s;
  logic [DATA_W-1:0] cur_s, nxt_s;
  logic              do_swap_s, pass_end_s, sort_done_s;

`ifdef SORT_EARLY_EXIT_EN
  logic swapped_q, swapped_d;
`endif

  assign idx_nxt_s  = idx_q + IDX_ONE;
  assign cur_s      = arr_q[idx_q[AW-1:0]];
  assign nxt_s      = arr_q[idx_nxt_s[AW-1:0]];
  // Unsigned compare; equal neighbours never swap, in either order.
  assign do_swap_s  = desc_q ? (cur_s < nxt_s) : (cur_s > nxt_s);
  assign pass_end_s = (idx_q == (PASS_LAST - pass_q));

`ifdef SORT_EARLY_EXIT_EN
  assign sort_done_s = (pass_q == PASS_LAST) || !(swapped_q || do_swap_s);
`else
  assign sort_done_s = (pass_q == PASS_LAST);
`endif

  // Next-state, array and output computation.
  always_comb begin
    state_d = state_q;
    arr_d   = arr_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    desc_d  = desc_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
    swapped_d = swapped_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          arr_d[0] = bus.data_in;
          idx_d    = IDX_ONE;
          state_d  = S_LOAD;
        end else if (bus.sort) begin
          desc_d  = bus.descend;
          idx_d   = IDX_ZERO;
          pass_d  = IDX_ZERO;
`ifdef SORT_EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
          state_d = S_SORT;
        end else if (bus.send) begin
          // The first word is presented as SEND is entered so valid spans exactly the SEND cycles.
          dout_d  = arr_q[0];
          valid_d = 1'b1;
          idx_d   = IDX_ZERO;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        arr_d[idx_q[AW-1:0]] = bus.data_in;
        if (idx_q == IDX_LAST) begin
          idx_d   = IDX_ZERO;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_nxt_s;
          state_d = S_LOAD;
        end
      end
      S_SORT: begin
        if (do_swap_s) begin
          arr_d[idx_q[AW-1:0]]     = nxt_s;
          arr_d[idx_nxt_s[AW-1:0]] = cur_s;
        end else begin
          arr_d = arr_q;
        end
`ifdef SORT_EARLY_EXIT_EN
        swapped_d = pass_end_s ? 1'b0 : (swapped_q || do_swap_s);
`endif
        if (pass_end_s) begin
          idx_d = IDX_ZERO;
          if (sort_done_s) begin
            state_d = S_WAIT;
          end else begin
            pass_d  = pass_q + IDX_ONE;
            state_d = S_SORT;
          end
        end else begin
          idx_d   = idx_nxt_s;
          state_d = S_SORT;
        end
      end
      S_WAIT: begin
        if (bus.send) begin
          dout_d  = arr_q[0];
          valid_d = 1'b1;
          idx_d   = IDX_ZERO;
          state_d = S_SEND;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_SEND: begin
        if (idx_q == IDX_LAST) begin
          valid_d = 1'b0;
          idx_d   = IDX_ZERO;
          state_d = S_IDLE;
        end else begin
          dout_d  = arr_q[idx_nxt_s[AW-1:0]];
          valid_d = 1'b1;
          idx_d   = idx_nxt_s;
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d   = (state_d == S_IDLE);
    busy_d    = (state_d == S_SORT);
    waiting_d = (state_d == S_WAIT);
  end

  // State, array, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        arr_q[i] <= {DATA_W{1'b0}};
      end
      idx_q     <= IDX_ZERO;
      pass_q    <= IDX_ZERO;
      desc_q    <= 1'b0;
      dout_q    <= {DATA_W{1'b0}};
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      waiting_q <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      arr_q     <= arr_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      desc_q    <= desc_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      waiting_q <= waiting_d;
`ifdef SORT_EARLY_EXIT_EN
      swapped_q <= swapped_d;
`endif
    end
  end

  assign bus.ready          = ready_q;
  assign bus.busy           = busy_q;
  assign bus.waiting        = waiting_q;
  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = valid_q;

endmodule

// File: tb/tb_param_bubble_sorter.sv
// Self-checking bench for param_bubble_sorter: directed cases plus randomized load/sort/send runs
// checked against a bucket-count sort model and an inversion-based busy-length model.
module tb_param_bubble_sorter;

  localparam int DW   = 4;
  localparam int DP   = 8;
  localparam int FULL = DP * (DP - 1) / 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_bubble_sorter_if #(.DATA_W(DW)) bus ();

  param_bubble_sorter #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] stim [DP];
  logic [DW-1:0] mdl  [DP];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ordering: count occurrences of each value, then emit them in order.
  task automatic model_sort(input logic d);
    int bucket [2**DW];
    int k;
    for (int v = 0; v < 2**DW; v++) bucket[v] = 0;
    for (int i = 0; i < DP; i++) bucket[mdl[i]]++;
    k = 0;
    for (int v = 0; v < 2**DW; v++) begin
      int val;
      val = d ? (2**DW - 1 - v) : v;
      for (int r = 0; r < bucket[val]; r++) begin
        mdl[k] = DW'(val);
        k++;
      end
    end
  endtask

  // Busy length: full triangle, or with early exit one pass per largest count of out-of-order predecessors, plus the clean pass.
  function automatic int exp_busy(input logic d);
    int total;
`ifdef SORT_EARLY_EXIT_EN
    int worst, np;
    worst = 0;
    for (int i = 0; i < DP; i++) begin
      int c;
      c = 0;
      for (int j = 0; j < i; j++) begin
        if (d ? (mdl[j] < mdl[i]) : (mdl[j] > mdl[i])) c++;
      end
      if (c > worst) worst = c;
    end
    np = worst + 1;
    if (np > DP - 1) np = DP - 1;
    total = 0;
    for (int p = 0; p < np; p++) total += DP - 1 - p;
`else
    total = FULL;
`endif
    return total;
  endfunction

  task automatic do_load(input logic with_sort);
    bus.load    = 1'b1;
    bus.sort    = with_sort;
    bus.data_in = stim[0];
    step();
    bus.load = 1'b0;
    bus.sort = 1'b0;
    chk("load_busy", bus.busy, 0);
    chk("load_ready", bus.ready, 0);
    for (int k = 1; k < DP; k++) begin
      bus.data_in = stim[k];
      step();
    end
    chk("load_done_ready", bus.ready, 1);
    for (int i = 0; i < DP; i++) mdl[i] = stim[i];
  endtask

  task automatic do_sort(input logic d, input logic poke_send);
    int want;
    int cnt;
    want = exp_busy(d);
    cnt  = 0;
    bus.sort    = 1'b1;
    bus.descend = d;
    step();
    bus.sort    = 1'b0;
    bus.descend = ~d;
    while (bus.busy === 1'b1 && cnt < 4 * FULL) begin
      bus.send = poke_send;
      bus.load = poke_send;
      cnt++;
      step();
    end
    bus.send = 1'b0;
    bus.load = 1'b0;
    chk("busy_cycles", cnt, want);
    chk("sort_waiting", bus.waiting, 1);
    model_sort(d);
  endtask

  task automatic hold_wait(input int n);
    bus.load = 1'b1;
    bus.sort = 1'b1;
    repeat (n) step();
    bus.load = 1'b0;
    bus.sort = 1'b0;
    chk("wait_hold", bus.waiting, 1);
    chk("wait_busy", bus.busy, 0);
  endtask

  task automatic do_send();
    bus.send = 1'b1;
    step();
    bus.send = 1'b0;
    for (int n = 0; n < DP; n++) begin
      chk("send_valid", bus.data_out_valid, 1);
      chk("send_data", bus.data_out, mdl[n]);
      step();
    end
    chk("send_end_valid", bus.data_out_valid, 0);
    chk("send_end_ready", bus.ready, 1);
    chk("send_end_hold", bus.data_out, mdl[DP-1]);
  endtask

  task automatic set_stim(input logic [31:0] packed_vals);
    for (int i = 0; i < DP; i++) stim[i] = packed_vals[4*(DP-1-i) +: 4];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic d;
    bus.load = 1'b0; bus.sort = 1'b0; bus.send = 1'b0;
    bus.descend = 1'b0; bus.data_in = '0;
    rst = 1'b0;
    step();
    step();
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_waiting", bus.waiting, 0);
    chk("rst_dout", bus.data_out, 0);
    chk("rst_valid", bus.data_out_valid, 0);
    rst = 1'b1;
    step();

    // Ascending and descending runs of the reference sequence.
    set_stim(32'h5371_0624);
    do_load(1'b0);
    do_sort(1'b0, 1'b0);
    do_send();
    do_load(1'b0);
    do_sort(1'b1, 1'b0);
    do_send();

    // Duplicates, then a second send from IDLE.
    set_stim(32'h3311_F0F0);
    do_load(1'b0);
    do_sort(1'b0, 1'b0);
    do_send();
    do_send();

    // load+sort together takes the load; send/load pokes during SORT are ignored.
    set_stim(32'h7654_3210);
    do_load(1'b1);
    do_send();
    do_sort(1'b0, 1'b1);
    hold_wait(3);
    do_send();

    // Already ascending input: early-exit length when enabled.
    set_stim(32'h0123_4567);
    do_load(1'b0);
    do_sort(1'b0, 1'b0);
    do_send();

    // Reset in the tenth SORT cycle.
    set_stim(32'h5371_0624);
    do_load(1'b0);
    bus.sort = 1'b1;
    step();
    bus.sort = 1'b0;
    repeat (9) step();
    chk("mid_busy", bus.busy, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_ready", bus.ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_dout", bus.data_out, 0);
    chk("mid_rst_valid", bus.data_out_valid, 0);
    for (int i = 0; i < DP; i++) mdl[i] = '0;
    do_send();

    // Randomized runs.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < DP; i++) stim[i] = DW'($urandom_range(0, 2**DW - 1));
      do_load(1'b0);
      d = 1'($urandom_range(0, 1));
      do_sort(d, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) hold_wait(int'($urandom_range(1, 4)));
      do_send();
      if ($urandom_range(0, 1) == 1) do_send();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
